// File: rtl/rgb_pwm_array.sv
// Avalon-MM RGB PWM array: NUM_LEDS x 3 channels, shared period, shadowed duties applied at period boundaries.
// Optional fade ramp toward shadow duties is built only when RGB_PWM_FADE_EN is defined.
module rgb_pwm_array #(
    parameter int NUM_LEDS   = 4,
    parameter int CNT_W      = 16,
    parameter int PERIOD_RST = 50000,
    parameter int FADE_STEP  = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [6:0]          avs_address,
    input  logic                avs_read,
    input  logic                avs_write,
    input  logic [31:0]         avs_writedata,
    output logic [31:0]         avs_readdata,
    output logic [NUM_LEDS-1:0] red_out,
    output logic [NUM_LEDS-1:0] green_out,
    output logic [NUM_LEDS-1:0] blue_out
);

    localparam int NUM_CH = 3 * NUM_LEDS;

    logic                ctrl_enable;
    logic                ctrl_invert;
    logic                ctrl_fade;
    logic [CNT_W-1:0]    period_shadow;
    logic [CNT_W-1:0]    period_active;
    logic [CNT_W-1:0]    counter;
    logic [CNT_W-1:0]    duty_shadow [NUM_CH];
    logic [CNT_W-1:0]    duty_active [NUM_CH];
    logic [NUM_CH-1:0]   pwm_q;
    logic [CNT_W:0]      counter_inc;
    logic                counter_last;
    logic                wr_ctrl;
    logic                enable_rise;
    logic                boundary;
    logic                load;
    logic                fade_now;
    logic [31:0]         rd_val;
    logic                unused_wdata;

    assign unused_wdata = ^avs_writedata;

    assign wr_ctrl      = avs_write && (avs_address == 7'd0);
    assign enable_rise  = wr_ctrl && avs_writedata[0] && !ctrl_enable;
    assign counter_inc  = {1'b0, counter} + {{CNT_W{1'b0}}, 1'b1};
    // A zero active period makes every cycle a boundary so a new PERIOD can still take effect.
    assign counter_last = counter_inc >= {1'b0, period_active};
    assign boundary     = ctrl_enable && counter_last;
    assign load         = boundary || enable_rise;
    assign fade_now     = enable_rise ? (avs_writedata[2] & ctrl_fade_built()) : ctrl_fade;

    function automatic logic ctrl_fade_built();
`ifdef RGB_PWM_FADE_EN
        return 1'b1;
`else
        return 1'b0;
`endif
    endfunction

`ifdef RGB_PWM_FADE_EN
    localparam logic [CNT_W-1:0] FADE_STEP_W = CNT_W'(FADE_STEP);

    function automatic logic [CNT_W-1:0] fade_toward(input logic [CNT_W-1:0] cur,
                                                     input logic [CNT_W-1:0] tgt);
        if (cur < tgt)
            return ((tgt - cur) > FADE_STEP_W) ? cur + FADE_STEP_W : tgt;
        else
            return ((cur - tgt) > FADE_STEP_W) ? cur - FADE_STEP_W : tgt;
    endfunction

    always_ff @(posedge clk) begin
        if (rst)
            ctrl_fade <= 1'b0;
        else if (wr_ctrl)
            ctrl_fade <= avs_writedata[2];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int ch = 0; ch < NUM_CH; ch++)
                duty_active[ch] <= '0;
        end else if (load) begin
            for (int ch = 0; ch < NUM_CH; ch++)
                duty_active[ch] <= fade_now ? fade_toward(duty_active[ch], duty_shadow[ch])
                                            : duty_shadow[ch];
        end
    end
`else
    logic unused_fade;
    assign unused_fade = fade_now ^ FADE_STEP[0];
    assign ctrl_fade   = 1'b0;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int ch = 0; ch < NUM_CH; ch++)
                duty_active[ch] <= '0;
        end else if (load) begin
            for (int ch = 0; ch < NUM_CH; ch++)
                duty_active[ch] <= duty_shadow[ch];
        end
    end
`endif

    // Registers read here hold pre-write values, so a same-cycle read returns the old contents.
    always_ff @(posedge clk) begin
        if (rst) begin
            ctrl_enable   <= 1'b0;
            ctrl_invert   <= 1'b0;
            period_shadow <= CNT_W'(PERIOD_RST);
            period_active <= CNT_W'(PERIOD_RST);
            for (int ch = 0; ch < NUM_CH; ch++)
                duty_shadow[ch] <= '0;
        end else begin
            if (wr_ctrl) begin
                ctrl_enable <= avs_writedata[0];
                ctrl_invert <= avs_writedata[1];
            end
            if (avs_write && (avs_address == 7'd1))
                period_shadow <= avs_writedata[CNT_W-1:0];
            for (int ch = 0; ch < NUM_CH; ch++) begin
                if (avs_write && (avs_address == 7'(ch + 2)))
                    duty_shadow[ch] <= avs_writedata[CNT_W-1:0];
            end
            if (load)
                period_active <= period_shadow;
        end
    end

    always_ff @(posedge clk) begin
        if (rst)
            counter <= '0;
        else if (!ctrl_enable || boundary)
            counter <= '0;
        else
            counter <= counter_inc[CNT_W-1:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pwm_q <= '0;
        end else begin
            for (int ch = 0; ch < NUM_CH; ch++) begin
                if (ctrl_enable && (period_active != '0))
                    pwm_q[ch] <= (counter < duty_active[ch]) ^ ctrl_invert;
                else
                    pwm_q[ch] <= 1'b0;
            end
        end
    end

    always_comb begin
        rd_val = '0;
        if (avs_address == 7'd0) begin
            rd_val[0] = ctrl_enable;
            rd_val[1] = ctrl_invert;
            rd_val[2] = ctrl_fade;
        end else if (avs_address == 7'd1) begin
            rd_val[CNT_W-1:0] = period_shadow;
        end
        for (int ch = 0; ch < NUM_CH; ch++) begin
            if (avs_address == 7'(ch + 2))
                rd_val[CNT_W-1:0] = duty_shadow[ch];
        end
    end

    always_ff @(posedge clk) begin
        if (rst)
            avs_readdata <= '0;
        else if (avs_read)
            avs_readdata <= rd_val;
    end

    always_comb begin
        for (int i = 0; i < NUM_LEDS; i++) begin
            red_out[i]   = pwm_q[3*i];
            green_out[i] = pwm_q[3*i+1];
            blue_out[i]  = pwm_q[3*i+2];
        end
    end

endmodule
